// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared encodings and constants for the memory bus arbiter
package mem_bus_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int BE_W       = DEF_DATA_W / 8;

    // Latency counter covers MEM_LAT up to 7, starvation counter up to 15.
    localparam int CNT_W    = 3;
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_bus_prio.sv
// rtl/mem_bus_prio.sv - data-first winner select with fetch starvation counter
module mem_bus_prio
    import mem_bus_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arbitrate,
    input  logic ibus_req,
    input  logic dbus_req,
    output logic grant_i,
    output logic grant_d
);

    logic [STARVE_W-1:0] starve_cnt;
    logic                starved;

    // Winner select: dbus first unless fetch has lost STARVE_MAX times in a row.
    always_comb begin
        starved = (starve_cnt == STARVE_W'(STARVE_MAX));
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (arbitrate) begin
            if (dbus_req && !starved) begin
                grant_d = 1'b1;
            end else if (ibus_req) begin
                grant_i = 1'b1;
            end else if (dbus_req) begin
                grant_d = 1'b1;
            end
        end
    end

    // Count consecutive arbitrations that fetch lost; any fetch grant clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && ibus_req && !starved) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one single-port memory between ibus and dbus
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ibus_req,
    input  logic [ADDR_W-1:0]     ibus_addr,
    output logic                  ibus_gnt,
    output logic                  ibus_rvalid,
    output logic [DATA_W-1:0]     ibus_rdata,
    input  logic                  dbus_req,
    input  logic                  dbus_we,
    input  logic [ADDR_W-1:0]     dbus_addr,
    input  logic [DATA_W-1:0]     dbus_wdata,
    input  logic [DATA_W/8-1:0]   dbus_be,
    output logic                  dbus_gnt,
    output logic                  dbus_rvalid,
    output logic [DATA_W-1:0]     dbus_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] lat_cnt, lat_cnt_nxt;
    owner_t           owner, owner_nxt;
    logic             owner_we, owner_we_nxt;

    logic rsp_cycle;
    logic arbitrate;
    logic grant_i;
    logic grant_d;

    // The response cycle doubles as an arbitration slot so grants can run back to back.
    assign rsp_cycle = rst && (state == ST_BUSY) && (lat_cnt == CNT_W'(1));
    assign arbitrate = rst && ((state == ST_IDLE) || rsp_cycle);

    mem_bus_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk       (clk),
        .rst       (rst),
        .arbitrate (arbitrate),
        .ibus_req  (ibus_req),
        .dbus_req  (dbus_req),
        .grant_i   (grant_i),
        .grant_d   (grant_d)
    );

    // State, latency counter and response owner registers; reset drops any open access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            lat_cnt  <= '0;
            owner    <= OWN_NONE;
            owner_we <= 1'b0;
        end else begin
            state    <= state_nxt;
            lat_cnt  <= lat_cnt_nxt;
            owner    <= owner_nxt;
            owner_we <= owner_we_nxt;
        end
    end

    // Next state: a grant always opens a new access, otherwise count down to the response.
    always_comb begin
        state_nxt    = state;
        lat_cnt_nxt  = lat_cnt;
        owner_nxt    = owner;
        owner_we_nxt = owner_we;
        if (grant_i || grant_d) begin
            state_nxt    = ST_BUSY;
            lat_cnt_nxt  = CNT_W'(MEM_LAT);
            owner_nxt    = grant_i ? OWN_I : OWN_D;
            owner_we_nxt = grant_d && dbus_we;
        end else if (state == ST_BUSY) begin
            if (rsp_cycle) begin
                state_nxt    = ST_IDLE;
                lat_cnt_nxt  = '0;
                owner_nxt    = OWN_NONE;
                owner_we_nxt = 1'b0;
            end else begin
                lat_cnt_nxt  = lat_cnt - CNT_W'(1);
            end
        end
    end

    // Outputs: grant and memory strobe from the winner, response routed to the owner.
    always_comb begin
        ibus_gnt    = grant_i;
        dbus_gnt    = grant_d;
        mem_en      = grant_i || grant_d;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_be      = '0;
        ibus_rvalid = 1'b0;
        ibus_rdata  = '0;
        dbus_rvalid = 1'b0;
        dbus_rdata  = '0;
        if (grant_d) begin
            mem_we    = dbus_we;
            mem_addr  = dbus_addr;
            mem_wdata = dbus_wdata;
            mem_be    = dbus_be;
        end else if (grant_i) begin
            mem_addr  = ibus_addr;
            mem_be    = '1;
        end
        if (rsp_cycle && (owner == OWN_I)) begin
            ibus_rvalid = 1'b1;
            ibus_rdata  = mem_rdata;
        end
        if (rsp_cycle && (owner == OWN_D)) begin
            dbus_rvalid = 1'b1;
            dbus_rdata  = owner_we ? '0 : mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed bench, three arbiters with MEM_LAT 1, 2 and 3
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            ibus_req;
    logic [31:0]     ibus_addr;
    logic            dbus_req;
    logic            dbus_we;
    logic [31:0]     dbus_addr;
    logic [31:0]     dbus_wdata;
    logic [BE_W-1:0] dbus_be;

    logic [2:0]      ibus_gnt_v, ibus_rvalid_v, dbus_gnt_v, dbus_rvalid_v, mem_en_v, mem_we_v;
    logic [31:0]     ibus_rdata_v [3];
    logic [31:0]     dbus_rdata_v [3];
    logic [31:0]     mem_addr_v   [3];
    logic [31:0]     mem_wdata_v  [3];
    logic [31:0]     mem_rdata_v  [3];
    logic [BE_W-1:0] mem_be_v     [3];

    int checks = 0;
    int failures = 0;

    for (genvar k = 0; k < 3; k++) begin : g_inst
        logic [31:0] mem  [0:255];
        logic [31:0] pipe [0:2];
        logic [7:0]  idx;

        assign idx = mem_addr_v[k][9:2];
        assign mem_rdata_v[k] = pipe[k];

        initial begin
            for (int j = 0; j < 256; j++) mem[j] = 32'h0;
            for (int j = 0; j < 3; j++) pipe[j] = 32'h0;
            mem[0] = 32'h1111_0000;
            mem[1] = 32'h2222_0004;
            mem[2] = 32'h3333_0008;
            mem[4] = 32'h0010_0093;
        end

        always @(posedge clk) begin
            pipe[0] <= mem_en_v[k] ? mem[idx] : 32'h0;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
            if (mem_en_v[k] && mem_we_v[k]) begin
                for (int b = 0; b < BE_W; b++)
                    if (mem_be_v[k][b]) mem[idx][8*b +: 8] <= mem_wdata_v[k][8*b +: 8];
            end
        end

        mem_bus_arbiter #(
            .ADDR_W     (32),
            .DATA_W     (32),
            .MEM_LAT    (k + 1),
            .STARVE_MAX (4)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .ibus_req    (ibus_req),
            .ibus_addr   (ibus_addr),
            .ibus_gnt    (ibus_gnt_v[k]),
            .ibus_rvalid (ibus_rvalid_v[k]),
            .ibus_rdata  (ibus_rdata_v[k]),
            .dbus_req    (dbus_req),
            .dbus_we     (dbus_we),
            .dbus_addr   (dbus_addr),
            .dbus_wdata  (dbus_wdata),
            .dbus_be     (dbus_be),
            .dbus_gnt    (dbus_gnt_v[k]),
            .dbus_rvalid (dbus_rvalid_v[k]),
            .dbus_rdata  (dbus_rdata_v[k]),
            .mem_en      (mem_en_v[k]),
            .mem_we      (mem_we_v[k]),
            .mem_addr    (mem_addr_v[k]),
            .mem_wdata   (mem_wdata_v[k]),
            .mem_be      (mem_be_v[k]),
            .mem_rdata   (mem_rdata_v[k])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        ibus_req = 1'b0;
        dbus_req = 1'b0;
        dbus_we  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] pat [10];
        int seen;
        int lat;
        logic [31:0] got;

        // Reset hold with both buses requesting.
        rst        = 1'b0;
        ibus_req   = 1'b1;
        ibus_addr  = 32'h10;
        dbus_req   = 1'b1;
        dbus_we    = 1'b0;
        dbus_addr  = 32'h100;
        dbus_wdata = 32'h0;
        dbus_be    = '0;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("reset_ctrl", {14'h0, ibus_gnt_v, dbus_gnt_v, mem_en_v, mem_we_v,
                               ibus_rvalid_v, dbus_rvalid_v}, 32'h0);
            chk("reset_addr", mem_addr_v[0] | mem_be_v[0], 32'h0);
            if (c < 2) tick();
        end
        tick();
        rst = 1'b1;
        sample();
        chk("first_gnt", {30'h0, ibus_gnt_v[0], dbus_gnt_v[0]}, 32'h1);
        tick();
        idle(4);

        // Lone fetch on MEM_LAT=1.
        ibus_req  = 1'b1;
        ibus_addr = 32'h10;
        sample();
        chk("fetch_gnt", {29'h0, ibus_gnt_v[0], mem_en_v[0], mem_we_v[0]}, 32'h6);
        chk("fetch_addr", mem_addr_v[0], 32'h10);
        chk("fetch_be", 32'(mem_be_v[0]), 32'hF);
        tick();
        ibus_req = 1'b0;
        sample();
        chk("fetch_rvalid", {31'h0, ibus_rvalid_v[0]}, 32'h1);
        chk("fetch_rdata", ibus_rdata_v[0], 32'h0010_0093);
        tick();
        sample();
        chk("fetch_rdata_idle", ibus_rdata_v[0], 32'h0);
        idle(4);

        // Store then load on MEM_LAT=2.
        dbus_req   = 1'b1;
        dbus_we    = 1'b1;
        dbus_addr  = 32'h100;
        dbus_wdata = 32'hDEAD_BEEF;
        dbus_be    = 4'b0011;
        sample();
        chk("store_gnt", {30'h0, dbus_gnt_v[1], mem_we_v[1]}, 32'h3);
        chk("store_be", 32'(mem_be_v[1]), 32'h3);
        chk("store_wdata", mem_wdata_v[1], 32'hDEAD_BEEF);
        tick();
        dbus_req = 1'b0;
        dbus_we  = 1'b0;
        sample();
        chk("store_no_early_rvalid", {31'h0, dbus_rvalid_v[1]}, 32'h0);
        tick();
        sample();
        chk("store_rvalid", {31'h0, dbus_rvalid_v[1]}, 32'h1);
        chk("store_rdata", dbus_rdata_v[1], 32'h0);
        idle(4);
        dbus_req = 1'b1;
        dbus_we  = 1'b0;
        dbus_be  = 4'b0000;
        sample();
        chk("load_gnt", {31'h0, dbus_gnt_v[1]}, 32'h1);
        tick();
        dbus_req = 1'b0;
        tick();
        sample();
        chk("load_rvalid", {31'h0, dbus_rvalid_v[1]}, 32'h1);
        chk("load_rdata", dbus_rdata_v[1], 32'h0000_BEEF);
        idle(4);

        // Contention with both requests held: D,D,D,D,I twice on MEM_LAT=1.
        pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        ibus_req  = 1'b1;
        ibus_addr = 32'h0;
        dbus_req  = 1'b1;
        dbus_we   = 1'b0;
        dbus_addr = 32'h100;
        for (int c = 0; c < 10; c++) begin
            sample();
            chk($sformatf("contend_%0d", c), {30'h0, ibus_gnt_v[0], dbus_gnt_v[0]}, 32'(pat[c]));
            tick();
        end
        idle(4);

        // Back-to-back fetches of addresses 0, 4, 8.
        ibus_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            ibus_addr = 32'(c * 4);
            if (c == 3) ibus_req = 1'b0;
            sample();
            chk($sformatf("b2b_gnt_%0d", c), {31'h0, ibus_gnt_v[0]}, (c < 3) ? 32'h1 : 32'h0);
            if (c < 3) chk($sformatf("b2b_addr_%0d", c), mem_addr_v[0], 32'(c * 4));
            if (c > 0) begin
                chk($sformatf("b2b_rvalid_%0d", c), {31'h0, ibus_rvalid_v[0]}, 32'h1);
                got = (c == 1) ? 32'h1111_0000 : (c == 2) ? 32'h2222_0004 : 32'h3333_0008;
                chk($sformatf("b2b_rdata_%0d", c), ibus_rdata_v[0], got);
            end
            tick();
        end
        idle(4);

        // Reset in the cycle after a dbus grant on MEM_LAT=3.
        dbus_req  = 1'b1;
        dbus_we   = 1'b0;
        dbus_addr = 32'h100;
        sample();
        chk("rst_mid_gnt", {31'h0, dbus_gnt_v[2]}, 32'h1);
        tick();
        dbus_req = 1'b0;
        rst      = 1'b0;
        sample();
        chk("rst_mid_outputs", {30'h0, dbus_gnt_v[2], dbus_rvalid_v[2]}, 32'h0);
        tick();
        rst  = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            sample();
            if (dbus_rvalid_v[2]) seen++;
            tick();
        end
        chk("rst_mid_no_rvalid", 32'(seen), 32'h0);
        ibus_req  = 1'b1;
        ibus_addr = 32'h10;
        sample();
        chk("rst_mid_fetch_gnt", {31'h0, ibus_gnt_v[2]}, 32'h1);
        tick();
        ibus_req = 1'b0;
        lat = -1;
        got = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            sample();
            if (ibus_rvalid_v[2] && lat < 0) begin
                lat = c;
                got = ibus_rdata_v[2];
            end
            tick();
        end
        chk("rst_mid_fetch_latency", 32'(lat), 32'h3);
        chk("rst_mid_fetch_rdata", got, 32'h0010_0093);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
